usb2_ep_in_packer: RTL and testbench
====================================

USB2_EP_IN_PACKER -- requirements
Module: usb2_ep_in_packer

Interface
REQ-001 Parameter TIMEOUT, default 16'd4096, idle cycles before a partial packet is committed; 0 disables the timeout.
REQ-002 phy_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 s_data  input  8  upstream byte.
REQ-005 s_valid  input  1  s_data is valid.
REQ-006 s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-007 s_last  input  1  qualifies the accepted byte as the last byte of a transfer.
REQ-008 max_pkt  input  10  max packet size, 1..512; 0 or >512 is treated as 512; sampled on IDLE->FILL.
REQ-009 zlp_en  input  1  append a zero-length packet after a transfer whose last packet is exactly max_pkt.
REQ-010 buf_in_addr  output  9  endpoint buffer write address.
REQ-011 buf_in_data  output  8  endpoint buffer write data.
REQ-012 buf_in_wren  output  1  endpoint buffer write strobe.
REQ-013 buf_in_ready  input  1  current endpoint buffer is free.
REQ-014 buf_in_commit  output  1  commit request, level, held until acknowledged.
REQ-015 buf_in_commit_len  output  10  committed byte count, 0..512.
REQ-016 buf_in_commit_ack  input  1  commit acknowledge, pulse of at least 1 cycle.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, FILL, COMMIT, ACK_LOW.
REQ-019 IDLE->FILL when buf_in_ready=1 and buf_in_commit_ack=0; latch the effective max_pkt into mp; clear cnt (10 bits).
REQ-020 s_ready = (state==FILL) && (cnt<mp) && !close, combinational from registers only.
REQ-021 On accept: buf_in_addr<=cnt[8:0], buf_in_data<=s_data, buf_in_wren<=1 for exactly one cycle (1-cycle latency); cnt<=cnt+1.
REQ-022 close is set when an accepted byte makes cnt+1==mp, when s_last is accepted, or when the timeout expires with cnt>0; FILL->COMMIT on the cycle after close.
REQ-023 The timeout counter resets on every accept and on FILL entry, and counts only in FILL with cnt>0.
REQ-024 In COMMIT: buf_in_commit=1 and buf_in_commit_len=cnt, both stable until buf_in_commit_ack=1 is sampled; then go to ACK_LOW.
REQ-025 In ACK_LOW: buf_in_commit=0; wait for buf_in_commit_ack=0, then go to IDLE.
REQ-026 ZLP: if s_last was accepted at cnt+1==mp and zlp_en=1, set zlp_pend. The next IDLE->FILL->COMMIT passes with cnt=0 and without accepting bytes, and zlp_pend is then cleared.
REQ-027 When s_last and full occur in the same cycle, exactly one commit is issued, plus a ZLP per REQ-026.
REQ-028 A timeout and an accept in the same cycle: the accept wins, and the timer reloads.
REQ-029 When buf_in_ready=0 in IDLE, remain in IDLE with s_ready=0 (backpressure, no data loss).
REQ-030 cnt never exceeds 512; buf_in_addr wraps never, because the maximum address is 511.

Reset
REQ-031 While reset_n=0: state=IDLE; cnt, mp=0; zlp_pend, close, timer=0; buf_in_wren, buf_in_commit, buf_in_commit_len, buf_in_addr, buf_in_data=0; busy=0; s_ready=0.
REQ-032 Reset asserted mid-packet or mid-commit drops the partial packet; no commit is issued after release until new bytes arrive.
REQ-033 Outputs take their reset values within the same cycle reset_n falls (asynchronous).

Structure
REQ-034 State encodings and the 512-byte buffer size constant live in a shared usb2_ep_pkg.
REQ-035 Single module; the timeout counter is a natural sub-module, usb2_idle_timer (load/enable/expired).

Verification
REQ-036 max_pkt=64, stream 64 bytes 0x00..0x3F with s_last on byte 63, zlp_en=0 -> 64 writes at addresses 0..63, one commit with len=64, busy returns to 0.
REQ-037 max_pkt=64, 150 bytes with s_last on the last byte -> commits of len 64, 64, 22 in order, each after the previous ack pulse; s_ready=0 during COMMIT/ACK_LOW.
REQ-038 max_pkt=8, zlp_en=1, 8 bytes with s_last -> commit len=8, then commit len=0, no extra wren.
REQ-039 TIMEOUT=16, 5 bytes without s_last, then idle -> commit len=5 exactly 16 cycles after the last accept plus 1.
REQ-040 buf_in_ready=0 for 100 cycles while s_valid=1 -> s_ready=0 and no wren; on ready=1 -> FILL next cycle.
REQ-041 reset_n pulsed low after 10 of 64 bytes -> all outputs 0 immediately; after release, 64 fresh bytes yield one commit with len=64.

Source files
------------

// File: rtl/usb2_ep_pkg.sv
// Shared definitions for the USB2 IN endpoint packer: FSM states,
// endpoint buffer size and the max-packet clamp helper.
package usb2_ep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_ACK_LOW = 2'd3
    } state_t;

    // Endpoint buffer capacity in bytes; also the largest legal max_pkt.
    localparam logic [9:0] BUF_BYTES = 10'd512;

    // A max_pkt of 0 or beyond the buffer size falls back to a full buffer.
    function automatic logic [9:0] eff_max_pkt(input logic [9:0] m);
        return ((m == 10'd0) || (m > BUF_BYTES)) ? BUF_BYTES : m;
    endfunction

endpackage

// File: rtl/usb2_idle_timer.sv
// Idle timer: counts enabled cycles since the last load and flags expiry
// once TIMEOUT enabled cycles have elapsed. TIMEOUT of 0 never expires.
module usb2_idle_timer #(
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam logic [15:0] LAST = TIMEOUT - 16'd1;

    logic [15:0] count_q, count_d;

    // Next count: reload wins, otherwise advance and hold at the terminal value.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i && (TIMEOUT != 16'd0) && (count_q != LAST)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (TIMEOUT != 16'd0) && (count_q == LAST);

endmodule

// File: rtl/usb2_ep_in_packer.sv
// USB2 IN endpoint packer: packs an upstream byte stream into endpoint
// buffer packets of up to max_pkt bytes, committing each packet on full,
// on s_last or on idle timeout, with optional zero-length packet.
module usb2_ep_in_packer
    import usb2_ep_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic        phy_clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    input  logic [9:0]  max_pkt,
    input  logic        zlp_en,
    output logic [8:0]  buf_in_addr,
    output logic [7:0]  buf_in_data,
    output logic        buf_in_wren,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [9:0]  buf_in_commit_len,
    input  logic        buf_in_commit_ack,
    output logic        busy
);
    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  mp_q, mp_d;
    logic        close_q, close_d;
    logic        zlp_pend_q, zlp_pend_d;
    logic [8:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        wren_q, wren_d;

    logic        accept;
    logic [9:0]  cnt_inc;
    logic        tmr_load, tmr_en, tmr_expired;

    assign s_ready  = (state_q == ST_FILL) && (cnt_q < mp_q) && !close_q;
    assign accept   = s_valid && s_ready;
    assign cnt_inc  = cnt_q + 10'd1;

    // Timer restarts on every accepted byte and whenever outside FILL,
    // and only runs once the packet holds at least one byte.
    assign tmr_load = accept || (state_q != ST_FILL);
    assign tmr_en   = (state_q == ST_FILL) && (cnt_q != 10'd0) && !close_q;

    usb2_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk_i     (phy_clk),
        .rst_ni    (reset_n),
        .load_i    (tmr_load),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Next-state and datapath decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mp_d       = mp_q;
        close_d    = close_q;
        zlp_pend_d = zlp_pend_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (buf_in_ready && !buf_in_commit_ack) begin
                    state_d    = ST_FILL;
                    mp_d       = eff_max_pkt(max_pkt);
                    cnt_d      = '0;
                    // A pending ZLP enters FILL already closed, so it
                    // commits with cnt=0 and never raises s_ready.
                    close_d    = zlp_pend_q;
                    zlp_pend_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (close_q) begin
                    state_d = ST_COMMIT;
                end else if (accept) begin
                    addr_d = cnt_q[8:0];
                    data_d = s_data;
                    wren_d = 1'b1;
                    cnt_d  = cnt_inc;
                    if ((cnt_inc == mp_q) || s_last) begin
                        close_d = 1'b1;
                    end
                    if (s_last && (cnt_inc == mp_q) && zlp_en) begin
                        zlp_pend_d = 1'b1;
                    end
                end else if (tmr_expired) begin
                    close_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                if (buf_in_commit_ack) begin
                    state_d = ST_ACK_LOW;
                end
            end
            ST_ACK_LOW: begin
                if (!buf_in_commit_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mp_q       <= '0;
            close_q    <= 1'b0;
            zlp_pend_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mp_q       <= mp_d;
            close_q    <= close_d;
            zlp_pend_q <= zlp_pend_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
        end
    end

    assign buf_in_addr       = addr_q;
    assign buf_in_data       = data_q;
    assign buf_in_wren       = wren_q;
    assign buf_in_commit     = (state_q == ST_COMMIT);
    assign buf_in_commit_len = (state_q == ST_COMMIT) ? cnt_q : '0;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb2_ep_in_packer.sv
// Testbench for usb2_ep_in_packer: directed scenarios plus randomized
// transfers checked against a packet-level reference model.
module tb_usb2_ep_in_packer;

    logic        phy_clk = 1'b0;
    logic        reset_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [9:0]  max_pkt;
    logic        zlp_en;
    logic [8:0]  buf_in_addr;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready;
    logic        buf_in_commit;
    logic [9:0]  buf_in_commit_len;
    logic        buf_in_commit_ack;
    logic        busy;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned rise_cyc    = 0;
    int unsigned last_acc    = 0;

    logic [16:0] wr_q[$];
    int          commit_q[$];
    logic [16:0] exp_wr[$];
    int          exp_c[$];
    int          sready_viol = 0;
    int          stab_viol   = 0;
    bit          win         = 1'b0;
    logic [9:0]  r_len;
    int          r_w;

    usb2_ep_in_packer #(
        .TIMEOUT (16'd16)
    ) dut (
        .phy_clk           (phy_clk),
        .reset_n           (reset_n),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_last            (s_last),
        .max_pkt           (max_pkt),
        .zlp_en            (zlp_en),
        .buf_in_addr       (buf_in_addr),
        .buf_in_data       (buf_in_data),
        .buf_in_wren       (buf_in_wren),
        .buf_in_ready      (buf_in_ready),
        .buf_in_commit     (buf_in_commit),
        .buf_in_commit_len (buf_in_commit_len),
        .buf_in_commit_ack (buf_in_commit_ack),
        .busy              (busy)
    );

    always #5 phy_clk = ~phy_clk;

    always @(posedge phy_clk) cyc <= cyc + 1;

    // Capture buffer writes; s_ready must stay low from commit until IDLE.
    always @(negedge phy_clk) begin
        if (buf_in_wren === 1'b1) wr_q.push_back({buf_in_addr, buf_in_data});
        if (buf_in_commit === 1'b1) win = 1'b1;
        else if (busy === 1'b0) win = 1'b0;
        if (win && s_ready !== 1'b0) sready_viol++;
    end

    // Endpoint side: records each commit, checks it is held stable, then acks.
    initial begin
        buf_in_commit_ack = 1'b0;
        forever begin
            @(negedge phy_clk);
            if (buf_in_commit === 1'b1) begin
                rise_cyc = cyc;
                r_len    = buf_in_commit_len;
                commit_q.push_back(int'(r_len));
                r_w = $urandom_range(0, 3);
                repeat (r_w) begin
                    @(negedge phy_clk);
                    if (buf_in_commit !== 1'b1 || buf_in_commit_len !== r_len) stab_viol++;
                end
                buf_in_commit_ack = 1'b1;
                r_w = $urandom_range(1, 2);
                repeat (r_w) @(negedge phy_clk);
                buf_in_commit_ack = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_q();
        wr_q.delete();
        commit_q.delete();
        exp_wr.delete();
        exp_c.delete();
        sready_viol = 0;
        stab_viol   = 0;
    endtask

    task automatic do_reset(input logic [9:0] mp);
        @(negedge phy_clk);
        reset_n = 1'b0;
        max_pkt = mp;
        repeat (2) @(negedge phy_clk);
        reset_n = 1'b1;
        @(posedge phy_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, output bit ok);
        int   n;
        logic rdy;
        s_data  = b;
        s_last  = last;
        s_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge phy_clk);
            rdy = s_ready;
            @(posedge phy_clk);
            #1;
            n++;
            if (rdy === 1'b1) ok = 1'b1;
        end
        s_valid  = 1'b0;
        s_last   = 1'b0;
        last_acc = cyc;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (t < 3000 && !(commit_q.size() >= exp_c.size() && busy === 1'b0)) begin
            @(negedge phy_clk);
            t++;
        end
        chk({tag, " done_in_time"}, 32'(t < 3000), 32'd1);
        repeat (30) @(negedge phy_clk);
        @(posedge phy_clk);
        #1;
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, " wr_count"}, wr_q.size(), exp_wr.size());
        n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s wr[%0d]", tag, i), 32'(wr_q[i]), 32'(exp_wr[i]));
        chk({tag, " commit_count"}, commit_q.size(), exp_c.size());
        n = (commit_q.size() < exp_c.size()) ? commit_q.size() : exp_c.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s commit_len[%0d]", tag, i), commit_q[i], exp_c[i]);
        chk({tag, " s_ready_in_commit"}, sready_viol, 0);
        chk({tag, " commit_stable"}, stab_viol, 0);
    endtask

    // Reference model: a transfer of n bytes is cut into packets of the
    // effective max packet size; byte i lands at offset i mod eff.
    task automatic run_xfer(input string tag, input int n, input logic [9:0] mp,
                            input bit zlp, input bit ramp, input bit with_last);
        int   eff;
        int   nacc;
        bit   ok;
        logic [7:0] b;
        eff  = (mp == 10'd0 || mp > 10'd512) ? 512 : int'(mp);
        clr_q();
        zlp_en = zlp;
        nacc = 0;
        for (int k = 0; k < n / eff; k++) exp_c.push_back(eff);
        if (n % eff != 0) exp_c.push_back(n % eff);
        else if (zlp && with_last) exp_c.push_back(0);
        for (int i = 0; i < n; i++) begin
            b = ramp ? 8'(i) : 8'($urandom);
            exp_wr.push_back({9'(i % eff), b});
            send_byte(b, with_last && (i == n - 1), ok);
            if (ok) nacc++;
            repeat ($urandom_range(0, 2)) begin
                @(posedge phy_clk);
                #1;
            end
        end
        chk({tag, " accepted"}, nacc, n);
        wait_done(tag);
        compare(tag);
    endtask

    initial begin
        int   bad;
        int   n;
        int   eff;
        bit   ok;
        logic [9:0] mp;
        reset_n      = 1'b0;
        s_data       = '0;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        max_pkt      = 10'd64;
        zlp_en       = 1'b0;
        buf_in_ready = 1'b1;
        #1;
        chk("reset wren", buf_in_wren, 0);
        chk("reset commit", buf_in_commit, 0);
        chk("reset busy", busy, 0);
        chk("reset s_ready", s_ready, 0);
        chk("reset addr", buf_in_addr, 0);
        do_reset(10'd64);

        // Single exact-size packet with ramp data.
        run_xfer("ramp64", 64, 10'd64, 1'b0, 1'b1, 1'b1);
        // Multi-packet transfer: 64, 64, 22.
        run_xfer("x150", 150, 10'd64, 1'b0, 1'b0, 1'b1);
        // Partial packet committed by idle timeout.
        run_xfer("tmo5", 5, 10'd64, 1'b0, 1'b0, 1'b0);
        chk("tmo latency", rise_cyc - last_acc, 32'd17);

        // Full packet with s_last and ZLP enabled: len 8 then len 0.
        do_reset(10'd8);
        run_xfer("zlp8", 8, 10'd8, 1'b1, 1'b0, 1'b1);

        // Randomized transfers, including clamped max_pkt values.
        for (int r = 0; r < 6; r++) begin
            case (r)
                0: mp = 10'd1;
                1: mp = 10'd0;
                2: mp = 10'd700;
                3: mp = 10'd512;
                4: mp = 10'($urandom_range(2, 100));
                default: mp = 10'($urandom_range(1, 512));
            endcase
            eff = (mp == 10'd0 || mp > 10'd512) ? 512 : int'(mp);
            if (r % 2 == 1) n = eff * $urandom_range(1, 2);
            else if (eff >= 512) n = $urandom_range(500, 600);
            else n = $urandom_range(1, 300);
            do_reset(mp);
            run_xfer($sformatf("rnd%0d_mp%0d_n%0d", r, mp, n), n, mp,
                     bit'($urandom_range(0, 1)), 1'b0, 1'b1);
        end

        // Backpressure: buffer not ready keeps the packer idle.
        buf_in_ready = 1'b0;
        do_reset(10'd64);
        clr_q();
        zlp_en  = 1'b0;
        s_data  = 8'hA5;
        s_last  = 1'b1;
        s_valid = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge phy_clk);
            if (s_ready !== 1'b0 || buf_in_wren !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("bp stall", bad, 0);
        buf_in_ready = 1'b1;
        @(posedge phy_clk);
        #1;
        chk("bp fill_next_cycle", busy, 1);
        @(posedge phy_clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        exp_wr.push_back({9'd0, 8'hA5});
        exp_c.push_back(1);
        wait_done("bp");
        compare("bp");

        // Reset in the middle of a packet drops it.
        do_reset(10'd64);
        zlp_en = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0, ok);
        reset_n = 1'b0;
        #1;
        chk("mid_rst wren", buf_in_wren, 0);
        chk("mid_rst addr", buf_in_addr, 0);
        chk("mid_rst data", buf_in_data, 0);
        chk("mid_rst commit", buf_in_commit, 0);
        chk("mid_rst len", buf_in_commit_len, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst s_ready", s_ready, 0);
        clr_q();
        repeat (2) @(negedge phy_clk);
        reset_n = 1'b1;
        repeat (40) @(negedge phy_clk);
        chk("mid_rst no_commit", commit_q.size(), 0);
        @(posedge phy_clk);
        #1;
        run_xfer("post_rst64", 64, 10'd64, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
